// File: rtl/fnn_pkg.sv
// ---------------------------------------------------------------------------
// fnn_pkg
// Purpose : shared constants and types for the final-layer argmax block.
//           BEFORE_DEC/AFTER_DEC describe the fixed-point format of a neuron
//           output; NEURON_OUT_WIDTH is the resulting word width.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package fnn_pkg;

    localparam int BEFORE_DEC       = 4;
    localparam int AFTER_DEC        = 15;
    localparam int NEURON_OUT_WIDTH = BEFORE_DEC + AFTER_DEC;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// ---------------------------------------------------------------------------
// argmax_cmp
// Purpose : registered running-maximum / index compare stage. One value is
//           offered per enabled cycle; the stored maximum is replaced only
//           when the new value is strictly greater (ties keep lower index).
// Ports   : clk, rstn          clock, async active-low reset
//           i_clr              zero the running max and index
//           i_en, i_data, i_idx candidate value and its index
//           o_max              running maximum (only with LAYER_ARGMAX_SCORE_OUT_EN)
//           o_idx              index of running maximum
// Macro   : LAYER_ARGMAX_SCORE_OUT_EN exposes o_max.
// ---------------------------------------------------------------------------
module argmax_cmp
    import fnn_pkg::*;
#(
    parameter int DATA_WIDTH = NEURON_OUT_WIDTH,
    parameter int IDX_WIDTH  = 6
)(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [IDX_WIDTH-1:0]  i_idx,
`ifdef LAYER_ARGMAX_SCORE_OUT_EN
    output logic [DATA_WIDTH-1:0] o_max,
`endif
    output logic [IDX_WIDTH-1:0]  o_idx
);

    logic [DATA_WIDTH-1:0] r_max;
    logic [IDX_WIDTH-1:0]  r_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (i_clr) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (i_en && (i_data > r_max)) begin
            r_max <= i_data;
            r_idx <= i_idx;
        end
    end

`ifdef LAYER_ARGMAX_SCORE_OUT_EN
    assign o_max = r_max;
`endif
    assign o_idx = r_idx;

endmodule

// File: rtl/layer_argmax.sv
// ---------------------------------------------------------------------------
// layer_argmax
// Purpose : collects the outputs of the final neuron layer as each neuron
//           raises its finish flag, scans the buffered values one per cycle
//           to find the largest (lowest index wins ties), holds the class
//           index until the consumer accepts it, then pulses restart to the
//           neurons for RESTART_CYCLES cycles.
// Ports   : clk, rstn       clock, async active-low reset
//           neuron_finish   per-neuron finish flags (level, rising edge = done)
//           neuron_data     packed unsigned neuron outputs
//           result_ready    consumer accepts class_idx
//           restart         restart strobe to all neurons
//           result_valid    class_idx valid
//           class_idx       index of the maximum neuron output
//           busy            high whenever not collecting
//           max_score       winning value (only with LAYER_ARGMAX_SCORE_OUT_EN)
// Macro   : LAYER_ARGMAX_SCORE_OUT_EN adds the max_score output.
// ---------------------------------------------------------------------------
module layer_argmax
    import fnn_pkg::*;
#(
    parameter int NEURON_COUNT   = 10,
    parameter int DATA_WIDTH     = NEURON_OUT_WIDTH,
    parameter int IDX_WIDTH      = 6,
    parameter int RESTART_CYCLES = 2
)(
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NEURON_COUNT-1:0]          neuron_finish,
    input  logic [NEURON_COUNT*DATA_WIDTH-1:0] neuron_data,
    input  logic                             result_ready,
    output logic                             restart,
    output logic                             result_valid,
    output logic [IDX_WIDTH-1:0]             class_idx,
`ifdef LAYER_ARGMAX_SCORE_OUT_EN
    output logic [DATA_WIDTH-1:0]            max_score,
`endif
    output logic                             busy
);

    localparam int CNT_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

    state_t                  r_state;
    logic [NEURON_COUNT-1:0] r_seen;
    logic [NEURON_COUNT-1:0] r_fin_hist;
    logic                    r_primed;
    logic [DATA_WIDTH-1:0]   r_buf [NEURON_COUNT];
    logic [IDX_WIDTH-1:0]    r_scan_idx;
    logic [CNT_W-1:0]        r_rcnt;
    logic                    r_restart;
    logic                    r_valid;

    logic [NEURON_COUNT-1:0] w_rise;
    logic [NEURON_COUNT-1:0] w_seen_next;
    logic                    w_all_seen;
    logic                    w_release_done;
    logic [DATA_WIDTH-1:0]   w_scan_data;
    logic [IDX_WIDTH-1:0]    w_cmp_idx;

    // Edges only count once the history has been loaded from live flags, so
    // a finish that is already high when collection (re)starts is ignored.
    always_comb begin
        w_rise = '0;
        if ((r_state == COLLECT) && r_primed)
            w_rise = neuron_finish & ~r_fin_hist;
    end

    assign w_seen_next    = r_seen | w_rise;
    assign w_all_seen     = &w_seen_next;
    assign w_release_done = (r_state == RELEASE) && (r_rcnt == CNT_W'(RESTART_CYCLES - 1));

    always_comb begin
        w_scan_data = '0;
        for (int i = 0; i < NEURON_COUNT; i++)
            if (r_scan_idx == IDX_WIDTH'(i))
                w_scan_data = r_buf[i];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NEURON_COUNT; i++)
                r_buf[i] <= '0;
        end else begin
            for (int i = 0; i < NEURON_COUNT; i++)
                if (w_rise[i])
                    r_buf[i] <= neuron_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= COLLECT;
            r_seen     <= '0;
            r_fin_hist <= '0;
            r_primed   <= 1'b0;
            r_scan_idx <= '0;
            r_rcnt     <= '0;
            r_restart  <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_fin_hist <= neuron_finish;
            r_primed   <= 1'b1;
            case (r_state)
                COLLECT: begin
                    r_seen <= w_seen_next;
                    if (w_all_seen) begin
                        r_state    <= SCAN;
                        r_scan_idx <= '0;
                    end
                end
                SCAN: begin
                    if (r_scan_idx == IDX_WIDTH'(NEURON_COUNT - 1)) begin
                        r_state <= HOLD;
                        r_valid <= 1'b1;
                    end else begin
                        r_scan_idx <= r_scan_idx + IDX_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        r_state   <= RELEASE;
                        r_valid   <= 1'b0;
                        r_restart <= 1'b1;
                        r_rcnt    <= '0;
                    end
                end
                RELEASE: begin
                    if (w_release_done) begin
                        r_state    <= COLLECT;
                        r_restart  <= 1'b0;
                        r_seen     <= '0;
                        // History is cleared and re-primed on the next clock.
                        r_fin_hist <= '0;
                        r_primed   <= 1'b0;
                    end else begin
                        r_rcnt <= r_rcnt + CNT_W'(1);
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    // Clear the compare stage on the edge that starts the scan.
    argmax_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_cmp (
        .clk    (clk),
        .rstn   (rstn),
        .i_clr  ((r_state == COLLECT) && w_all_seen),
        .i_en   (r_state == SCAN),
        .i_data (w_scan_data),
        .i_idx  (r_scan_idx),
`ifdef LAYER_ARGMAX_SCORE_OUT_EN
        .o_max  (max_score),
`endif
        .o_idx  (w_cmp_idx)
    );

    assign restart      = r_restart;
    assign result_valid = r_valid;
    assign class_idx    = w_cmp_idx;
    assign busy         = (r_state != COLLECT);

endmodule

// File: tb/tb_layer_argmax.sv
module tb_layer_argmax;

    localparam int N  = 10;
    localparam int DW = 19;
    localparam int IW = 6;
    localparam int RC = 2;

    typedef logic [DW-1:0] vals_t [N];

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      neuron_finish;
    logic [N*DW-1:0]   neuron_data;
    logic              result_ready;
    logic              restart;
    logic              result_valid;
    logic [IW-1:0]     class_idx;
    logic              busy;
`ifdef LAYER_ARGMAX_SCORE_OUT_EN
    logic [DW-1:0]     max_score;
`endif

    int total = 0;
    int bad   = 0;
    int          exp_idx_q[$];
    logic [DW-1:0] exp_score_q[$];

    always #5 clk = ~clk;

    layer_argmax #(
        .NEURON_COUNT   (N),
        .DATA_WIDTH     (DW),
        .IDX_WIDTH      (IW),
        .RESTART_CYCLES (RC)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .neuron_finish (neuron_finish),
        .neuron_data   (neuron_data),
        .result_ready  (result_ready),
        .restart       (restart),
        .result_valid  (result_valid),
        .class_idx     (class_idx),
`ifdef LAYER_ARGMAX_SCORE_OUT_EN
        .max_score     (max_score),
`endif
        .busy          (busy)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference argmax: first index holding the strictly largest value.
    task automatic model_push(input vals_t v);
        int best = 0;
        logic [DW-1:0] m = v[0];
        for (int i = 1; i < N; i++)
            if (v[i] > m) begin
                m    = v[i];
                best = i;
            end
        exp_idx_q.push_back(best);
        exp_score_q.push_back(m);
    endtask

    // Lower all finish flags for one cycle, then raise them one per cycle.
    // Returns right after the last flag is raised.
    task automatic drive_edges(input vals_t v, input bit rev);
        for (int i = 0; i < N; i++) neuron_data[i*DW +: DW] = v[i];
        neuron_finish = '0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            int i;
            i = rev ? (N - 1 - k) : k;
            neuron_finish[i] = 1'b1;
            if (k != N - 1) @(negedge clk);
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (result_valid !== 1'b1 && cnt < 200);
    endtask

    task automatic wait_idle(output int rc);
        int n = 0;
        rc = (restart === 1'b1) ? 1 : 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
            if (restart === 1'b1) rc++;
        end
    endtask

    task automatic test_reset();
        rstn          = 1'b0;
        neuron_finish = '0;
        neuron_data   = '0;
        result_ready  = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (restart !== 1'b0) begin bad++; $display("FAIL reset_restart got=%b want=0", restart); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", result_valid); end
        total++; if (class_idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d want=0", class_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef LAYER_ARGMAX_SCORE_OUT_EN
        total++; if (max_score !== '0) begin bad++; $display("FAIL reset_score got=%0d want=0", max_score); end
`endif
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Shared body for passes with ready already high.
    task automatic run_pass(input string name, input vals_t v, input bit rev);
        int cnt, rc, ei;
        logic [DW-1:0] es;
        result_ready = 1'b1;
        model_push(v);
        drive_edges(v, rev);
        wait_valid(cnt);
        ei = exp_idx_q.pop_front();
        es = exp_score_q.pop_front();
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b want=1", name, result_valid); end
        total++; if (cnt != N + 1) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cnt, N + 1); end
        total++; if (class_idx !== IW'(ei)) begin bad++; $display("FAIL %s_idx got=%0d want=%0d", name, class_idx, ei); end
`ifdef LAYER_ARGMAX_SCORE_OUT_EN
        total++; if (max_score !== es) begin bad++; $display("FAIL %s_score got=%0d want=%0d", name, max_score, es); end
`endif
        @(negedge clk);
        total++; if (result_valid !== 1'b0 || restart !== 1'b1) begin bad++; $display("FAIL %s_handshake got valid=%b restart=%b want valid=0 restart=1", name, result_valid, restart); end
        wait_idle(rc);
        total++; if (rc != RC || busy !== 1'b0) begin bad++; $display("FAIL %s_restart got=%0d busy=%b want=%0d busy=0", name, rc, busy, RC); end
    endtask

    task automatic test_tie();
        vals_t v = '{default: '0};
        v[0] = 5; v[1] = 9; v[2] = 3; v[3] = 9;
        run_pass("tie", v, 1'b0);
    endtask

    task automatic test_zero();
        vals_t v = '{default: '0};
        run_pass("zero", v, 1'b0);
    endtask

    task automatic test_reverse();
        vals_t v;
        for (int i = 0; i < N; i++) v[i] = DW'(1000 * i + 17);
        v[7] = 19'h7FFFF;
        run_pass("reverse", v, 1'b1);
    endtask

    task automatic test_hold_stall();
        vals_t v = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        int cnt, rc, ei;
        logic [DW-1:0] es;
        logic [IW-1:0] held;
        result_ready = 1'b0;
        model_push(v);
        drive_edges(v, 1'b0);
        wait_valid(cnt);
        ei = exp_idx_q.pop_front();
        es = exp_score_q.pop_front();
        total++; if (class_idx !== IW'(ei) || result_valid !== 1'b1) begin bad++; $display("FAIL stall_idx got=%0d valid=%b want=%0d valid=1", class_idx, result_valid, ei); end
`ifdef LAYER_ARGMAX_SCORE_OUT_EN
        total++; if (max_score !== es) begin bad++; $display("FAIL stall_score got=%0d want=%0d", max_score, es); end
`endif
        held = IW'(ei);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if (result_valid !== 1'b1 || class_idx !== held || restart !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cycle=%0d got valid=%b idx=%0d restart=%b want 1/%0d/0", c, result_valid, class_idx, restart, held);
            end
        end
        result_ready = 1'b1;
        @(negedge clk);
        total++; if (result_valid !== 1'b0 || restart !== 1'b1) begin bad++; $display("FAIL stall_handshake got valid=%b restart=%b want 0/1", result_valid, restart); end
        wait_idle(rc);
        total++; if (rc != RC) begin bad++; $display("FAIL stall_restart_len got=%0d want=%0d", rc, RC); end
    endtask

    // Finish flags stay high through RELEASE into COLLECT; edges during
    // SCAN must not disturb the buffered values.
    task automatic test_finish_held();
        vals_t v;
        int cnt, rc, ei;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_false_capture cycle=%0d busy=%b want=0", c, busy); end
        end
        for (int i = 0; i < N; i++) v[i] = DW'(10 * (i + 1));
        result_ready = 1'b1;
        model_push(v);
        drive_edges(v, 1'b0);
        @(negedge clk);
        neuron_finish[2] = 1'b0;
        @(negedge clk);
        neuron_data[2*DW +: DW] = 19'h7FFFF;
        neuron_finish[2] = 1'b1;
        wait_valid(cnt);
        ei = exp_idx_q.pop_front();
        void'(exp_score_q.pop_front());
        total++; if (class_idx !== IW'(ei) || result_valid !== 1'b1) begin bad++; $display("FAIL scan_ignore got=%0d valid=%b want=%0d", class_idx, result_valid, ei); end
        @(negedge clk);
        wait_idle(rc);
    endtask

    task automatic test_overwrite();
        vals_t v = '{default: DW'(50)};
        int cnt, rc, ei;
        v[3] = 60;
        v[0] = 10;
        result_ready = 1'b1;
        model_push(v);
        for (int i = 0; i < N; i++) neuron_data[i*DW +: DW] = v[i];
        neuron_data[0 +: DW] = 200;
        neuron_finish = '0;
        @(negedge clk);
        neuron_finish[0] = 1'b1;
        @(negedge clk);
        neuron_finish[0] = 1'b0;
        @(negedge clk);
        neuron_data[0 +: DW] = v[0];
        neuron_finish[0] = 1'b1;
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            neuron_finish[i] = 1'b1;
        end
        wait_valid(cnt);
        ei = exp_idx_q.pop_front();
        void'(exp_score_q.pop_front());
        total++; if (class_idx !== IW'(ei) || result_valid !== 1'b1) begin bad++; $display("FAIL overwrite got=%0d valid=%b want=%0d", class_idx, result_valid, ei); end
        @(negedge clk);
        wait_idle(rc);
    endtask

    task automatic test_reset_mid_scan();
        vals_t v;
        for (int i = 0; i < N; i++) v[i] = DW'(i + 100);
        result_ready = 1'b1;
        drive_edges(v, 1'b0);
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midscan_busy got=%b want=1", busy); end
        #2 rstn = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || restart !== 1'b0 || class_idx !== '0) begin
            bad++;
            $display("FAIL async_reset got busy=%b valid=%b restart=%b idx=%0d want all 0", busy, result_valid, restart, class_idx);
        end
        neuron_finish = '0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < N; i++) v[i] = DW'($urandom_range(0, 32'h7FFFF));
        run_pass("post_reset", v, 1'b0);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_zero();
        test_reverse();
        test_hold_stall();
        test_finish_held();
        test_overwrite();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_argmax.md
LAYER_ARGMAX -- requirements
Module: layer_argmax

Interface
REQ-001 Parameter NEURON_COUNT, default 10, is the number of neurons in the final layer (range 2..64).
REQ-002 Parameter DATA_WIDTH, default 19, is the width of each neuron output, equal to BEFORE_DEC+15 with BEFORE_DEC=4.
REQ-003 Parameter IDX_WIDTH, default 6, is the width of class_idx and SHALL satisfy 2^IDX_WIDTH >= NEURON_COUNT.
REQ-004 Parameter RESTART_CYCLES, default 2, is the number of cycles restart is held high.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 neuron_finish  input  NEURON_COUNT  finish flag of neuron i, one bit per neuron.
REQ-008 neuron_data  input  NEURON_COUNT*DATA_WIDTH  unsigned output of neuron i, in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 result_ready  input  1  consumer accepts the result.
REQ-010 restart  output  1  restart strobe broadcast to all neurons.
REQ-011 result_valid  output  1  class_idx is valid.
REQ-012 class_idx  output  IDX_WIDTH  index of the maximum neuron output.
REQ-013 busy  output  1  high in every state other than COLLECT.

Function
REQ-014 The block SHALL use the four states COLLECT, SCAN, HOLD and RELEASE.
REQ-015 In COLLECT, the block SHALL treat a 0->1 transition on neuron_finish[i] (registered edge detect) as a capture event, capture that neuron's data slice into a buffer and set seen[i].
REQ-016 A neuron_finish bit that is already high when COLLECT is entered SHALL NOT count as a capture event.
REQ-017 The edge detect of REQ-016 is required because neuron finish stays high until the next compute pass.
REQ-018 When every bit of seen is set, including a final edge arriving in the current cycle, the block SHALL enter SCAN on the next edge.
REQ-019 SCAN SHALL compare one buffered value per cycle for index 0..NEURON_COUNT-1, NEURON_COUNT cycles in total.
REQ-020 The running maximum SHALL update only when a value is strictly greater, so ties resolve to the lowest index.
REQ-021 If all values are 0, class_idx SHALL be 0.
REQ-022 The cycle after the last SCAN compare, the block SHALL enter HOLD with result_valid=1, class_idx stable.
REQ-023 Latency from the cycle in which seen becomes complete to result_valid=1 SHALL be NEURON_COUNT+1 cycles.
REQ-024 In HOLD, result_valid and class_idx SHALL remain stable until result_ready=1 is sampled with result_valid=1.
REQ-025 On the HOLD handshake, the block SHALL enter RELEASE and drop result_valid on the same edge.
REQ-026 If result_ready is already high on entry to HOLD, the handshake SHALL complete in the first HOLD cycle.
REQ-027 In RELEASE, restart SHALL be 1 for exactly RESTART_CYCLES cycles.
REQ-028 On leaving RELEASE, the block SHALL clear seen and the edge-detect history, then return to COLLECT.
REQ-029 Capture events during SCAN, HOLD or RELEASE SHALL be ignored, with no buffer overwrite.
REQ-030 A second rising edge on an already-seen neuron during COLLECT SHALL overwrite that neuron's buffer and leave seen unchanged.
REQ-031 Comparisons SHALL be unsigned over DATA_WIDTH bits.

Reset
REQ-032 While rstn=0, state SHALL be COLLECT, seen=0, edge history=0, buffers=0, running max=0.
REQ-033 While rstn=0, outputs SHALL be restart=0, result_valid=0, class_idx=0, busy=0 (and max_score=0 when present).
REQ-034 Reset asserted mid-SCAN, HOLD or RELEASE SHALL abort immediately to the reset values.
REQ-035 After reset, the edge history SHALL be primed from neuron_finish on the first clock.

Configuration
REQ-036 When macro LAYER_ARGMAX_SCORE_OUT_EN is defined, the block SHALL add output max_score, DATA_WIDTH bits, equal to the winning value and valid with result_valid.
REQ-037 Without LAYER_ARGMAX_SCORE_OUT_EN, the max_score port and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-038 Package fnn_pkg SHALL hold the state enum, BEFORE_DEC, AFTER_DEC and the derived NEURON_OUT_WIDTH constant.
REQ-039 One sub-module, argmax_cmp, SHALL hold the registered running-max/index compare stage, instantiated once.

Verification
REQ-040 The bench SHALL drive data {5,9,3,9,0,...} with finish edges in index order -> class_idx=1 (tie resolved to lower index) and result_valid at last-edge+NEURON_COUNT+1.
REQ-041 The bench SHALL drive all-zero data -> class_idx=0 (and max_score=0 when enabled).
REQ-042 The bench SHALL drive reverse-order finish edges with neuron 7 = 0x7FFFF -> class_idx=7.
REQ-043 The bench SHALL hold result_ready=0 for 20 cycles in HOLD -> outputs stable and restart=0, then ready=1 -> restart high for exactly 2 cycles.
REQ-044 The bench SHALL keep finish high across RELEASE and start a new pass -> no false capture until fresh 0->1 edges.
REQ-045 The bench SHALL assert rstn=0 during SCAN -> all outputs 0 asynchronously, and a clean pass completes afterwards.
